seq_chunk_adder: RTL and testbench

Multi-cycle, parametrised ripple adder/subtractor for the datapath. It is the successor to the fixed 5-bit full-adder chain. Each cycle it adds one CHUNK-bit slice of two WIDTH-bit operands and registers the carry between slices, so wide adds fit a short critical path. Operands enter and results leave over valid/ready handshakes. It also supports subtract mode and reports carry, signed overflow and zero flags.

---
 rtl/seq_chunk_adder.sv | 117 +++++++++++
 tb/tb_seq_chunk_adder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// Multi-cycle chunked ripple adder/subtractor: one CHUNK-bit slice per cycle,
// carry registered between slices, valid/ready handshakes on both sides.
module seq_chunk_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned CW     = CHUNK + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [IDXW-1:0]  idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_out_q;
    logic             overflow_q;
    logic             zero_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [31:0]      base_c;
    logic [CHUNK-1:0] a_sl_c;
    logic [CHUNK-1:0] b_sl_c;
    logic [CHUNK:0]   slice_c;
    logic [WIDTH-1:0] slice_mask_c;
    logic [WIDTH-1:0] sum_d;
    logic             msb_cin_c;

    // Current slice add and the sum with that slice merged in.
    always_comb begin
        base_c       = 32'(idx_q) * 32'(CHUNK);
        a_sl_c       = CHUNK'(a_q >> base_c);
        b_sl_c       = CHUNK'(b_q >> base_c);
        slice_c      = CW'(a_sl_c) + CW'(b_sl_c) + CW'(carry_q);
        slice_mask_c = WIDTH'({CHUNK{1'b1}}) << base_c;
        sum_d        = (sum_q & ~slice_mask_c) | (WIDTH'(slice_c[CHUNK-1:0]) << base_c);
        // Carry into the slice MSB; on the final slice this is the carry into bit WIDTH-1.
        msb_cin_c    = slice_c[CHUNK-1] ^ a_sl_c[CHUNK-1] ^ b_sl_c[CHUNK-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b + ~borrow_in.
                        a_q        <= a;
                        b_q        <= sub ? ~b : b;
                        carry_q    <= carry_in ^ sub;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= slice_c[CHUNK];
                    idx_q   <= idx_q + IDXW'(1);
                    if (idx_q == IDXW'(NCHUNK - 1)) begin
                        carry_out_q <= slice_c[CHUNK];
                        overflow_q  <= msb_cin_c ^ slice_c[CHUNK];
                        zero_q      <= (sum_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed and random checks of seq_chunk_adder with CHUNK=8 plus a CHUNK=32
// instance for single-cycle latency.
module tb_seq_chunk_adder;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset, in_valid, out_ready, carry_in, sub;
    logic [W-1:0] a, b;
    logic         in_ready, out_valid, carry_out, overflow, zero;
    logic [W-1:0] sum;
    logic         in_valid2, out_ready2;
    logic         in_ready2, out_valid2, carry_out2, overflow2, zero2;
    logic [W-1:0] sum2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carry_in(carry_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a), .b(b), .carry_in(carry_in), .sub(sub),
        .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2),
        .carry_out(carry_out2), .overflow(overflow2), .zero(zero2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: returns {overflow, carry_out, sum}, overflow from operand signs.
    function automatic logic [33:0] model(input logic [31:0] va, input logic [31:0] vb,
                                          input logic vc, input logic vs);
        logic [32:0] r;
        logic        ov;
        if (!vs) begin
            r  = {1'b0, va} + {1'b0, vb} + 33'(vc);
            ov = (va[31] == vb[31]) && (r[31] != va[31]);
        end else begin
            r  = {1'b0, va} + {1'b0, ~vb} + 33'(!vc);
            ov = (va[31] != vb[31]) && (r[31] != va[31]);
        end
        return {ov, r[32], r[31:0]};
    endfunction

    // One operation on the CHUNK=8 instance with out_ready held high.
    task automatic do_op(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                         input logic vs, input logic [31:0] es, input logic ec,
                         input logic eo, input logic ez);
        int lat;
        a = va; b = vb; carry_in = vc; sub = vs; in_valid = 1'b1;
        check("in_ready_idle", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        a = ~va; b = va ^ vb; carry_in = ~vc; sub = ~vs;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", 64'(lat), 64'd4);
        check("sum", 64'(sum), 64'(es));
        check("carry_out", 64'(carry_out), 64'(ec));
        check("overflow", 64'(overflow), 64'(eo));
        check("zero", 64'(zero), 64'(ez));
        check("in_ready_done", 64'(in_ready), 64'd0);
        tick();
        check("in_ready_after", 64'(in_ready), 64'd1);
        check("out_valid_after", 64'(out_valid), 64'd0);
        check("sum_held_idle", 64'(sum), 64'(es));
    endtask

    // One operation on the CHUNK=32 instance: result one edge after accept.
    task automatic do_op32(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                           input logic vs, input logic [31:0] es, input logic ec,
                           input logic eo, input logic ez);
        a = va; b = vb; carry_in = vc; sub = vs; in_valid2 = 1'b1;
        check("w32_in_ready", 64'(in_ready2), 64'd1);
        tick();
        in_valid2 = 1'b0;
        check("w32_not_yet_valid", 64'(out_valid2), 64'd0);
        tick();
        check("w32_out_valid", 64'(out_valid2), 64'd1);
        check("w32_sum", 64'(sum2), 64'(es));
        check("w32_carry_out", 64'(carry_out2), 64'(ec));
        check("w32_overflow", 64'(overflow2), 64'(eo));
        check("w32_zero", 64'(zero2), 64'(ez));
        tick();
        check("w32_in_ready_after", 64'(in_ready2), 64'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rc, rs;
        logic [33:0] r;
        int          lat;

        reset = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
        a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_flags", 64'({carry_out, overflow, zero}), 64'd0);
        check("rst_in_ready32", 64'(in_ready2), 64'd1);

        // Basic add, full ripple, overflow and subtract.
        do_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b0);
        do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        do_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        do_op(32'h0000_0009, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 1'b0, 1'b0);

        // Backpressure in DONE with in_valid asserted throughout RUN and DONE.
        out_ready = 1'b0;
        a = 32'h0000_0010; b = 32'h0000_0020; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; sub = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("bp_in_ready_run", 64'(in_ready), 64'd0);
            tick();
            lat++;
        end
        check("bp_latency", 64'(lat), 64'd4);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_sum", 64'(sum), 64'h30);
            check("bp_flags", 64'({carry_out, overflow, zero}), 64'd0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_ready", 64'(in_ready), 64'd1);
        tick();
        tick();
        check("bp_no_queued_op", 64'(out_valid), 64'd0);
        check("bp_idle_ready", 64'(in_ready), 64'd1);

        // Reset two cycles into RUN discards the operation.
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; carry_in = 1'b1; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sum", 64'(sum), 64'd0);
        check("mid_rst_flags", 64'({carry_out, overflow, zero}), 64'd0);
        tick();
        check("mid_rst_no_output", 64'(out_valid), 64'd0);
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

        // Back-to-back random operations at the maximum issue rate.
        for (int i = 0; i < 100; i++) begin
            ra = $urandom; rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            r  = model(ra, rb, rc, rs);
            do_op(ra, rb, rc, rs, r[31:0], r[32], r[33], r[31:0] == 32'd0);
        end

        // Degenerate CHUNK == WIDTH instance.
        do_op32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        do_op32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        do_op32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        do_op32(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
